// File: rtl/multi_frame_delay_pkg.sv
// Shared types and default parameters for the multi-channel frame delay block.
package multi_frame_delay_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } chan_state_t;

    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_WIDTH    = 5;
    localparam int unsigned DEF_DELAY    = 5;

endpackage

// File: rtl/multi_frame_delay_if.sv
// Control/status bundle between game-control logic (master) and the frame delay block (slave).
interface multi_frame_delay_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 5
);
    logic                startOfFrame;
    logic [CHANNELS-1:0] input_signal;
    logic [CHANNELS-1:0] clear;
    logic [CHANNELS-1:0] load;
    logic [WIDTH-1:0]    load_value;
    logic [CHANNELS-1:0] output_signal;
    logic [CHANNELS-1:0] output_pulse;
    logic                busy;

    modport master (
        output startOfFrame, input_signal, clear, load, load_value,
        input  output_signal, output_pulse, busy
    );

    modport slave (
        input  startOfFrame, input_signal, clear, load, load_value,
        output output_signal, output_pulse, busy
    );
endinterface

// File: rtl/multi_frame_delay_channel.sv
// One frame-delay channel: hold mode (count enabled frames) or trigger mode (edge-armed).
// Optional periodic restart from DONE under MULTI_FRAME_DELAY_AUTO_RESTART_EN.
module frame_delay_channel
    import multi_frame_delay_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned DEFAULT_DELAY = DEF_DELAY,
    parameter bit          TRIGGER       = 1'b0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             sof_i,
    input  logic             in_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             out_o,
    output logic             pulse_o,
    output logic             counting_c
);

    localparam chan_state_t START_STATE = TRIGGER ? IDLE : COUNTING;

    chan_state_t      state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] delay_q, delay_d;
    logic             in_q, in_d;
    logic             out_q, out_d;
    logic             pulse_q, pulse_d;
    logic             qual_c;

    assign qual_c = sof_i & (TRIGGER ? 1'b1 : in_i);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= START_STATE;
            counter_q <= WIDTH'(DEFAULT_DELAY);
            delay_q   <= WIDTH'(DEFAULT_DELAY);
            in_q      <= 1'b0;
            out_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            delay_q   <= delay_d;
            in_q      <= in_d;
            out_q     <= out_d;
            pulse_q   <= pulse_d;
        end
    end

    // Clear overrides everything; load only retargets delay_q and never touches the count.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        delay_d   = delay_q;
        in_d      = in_i;
        out_d     = out_q;
        pulse_d   = 1'b0;

        if (load_i) begin
            delay_d = load_value_i;
        end

        if (clear_i) begin
            counter_d = delay_q;
            state_d   = START_STATE;
            out_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (TRIGGER && !in_q && in_i) begin
                        counter_d = delay_q;
                        state_d   = COUNTING;
                    end
                end
                COUNTING: begin
                    if (qual_c) begin
                        if (counter_q != '0) begin
                            counter_d = counter_q - WIDTH'(1);
                        end else begin
                            state_d = DONE;
                            out_d   = 1'b1;
                            pulse_d = 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef MULTI_FRAME_DELAY_AUTO_RESTART_EN
                    // Restart frame is the first of the next D+1, so pulses repeat every D+1 frames.
                    if (qual_c) begin
                        if (delay_q == '0) begin
                            pulse_d = 1'b1;
                        end else begin
                            counter_d = delay_q - WIDTH'(1);
                            state_d   = COUNTING;
                        end
                    end
`endif
                end
                default: begin
                    state_d = START_STATE;
                end
            endcase
        end
    end

    assign out_o      = out_q;
    assign pulse_o    = pulse_q;
    assign counting_c = (state_q == COUNTING);

endmodule

// File: rtl/multi_frame_delay.sv
// Multi-channel frame delay: CHANNELS independent frame-quantised delays plus a registered busy flag.
// Build option: MULTI_FRAME_DELAY_AUTO_RESTART_EN makes DONE channels re-arm for periodic pulses.
module multi_frame_delay
    import multi_frame_delay_pkg::*;
#(
    parameter int unsigned         CHANNELS      = DEF_CHANNELS,
    parameter int unsigned         WIDTH         = DEF_WIDTH,
    parameter int unsigned         DEFAULT_DELAY = DEF_DELAY,
    parameter logic [CHANNELS-1:0] TRIGGER_MASK  = '0
) (
    input  logic                clk,
    input  logic                resetN,
    multi_frame_delay_if.slave  bus
);

    logic [CHANNELS-1:0] out_vec;
    logic [CHANNELS-1:0] pulse_vec;
    logic [CHANNELS-1:0] counting_c;
    logic                busy_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        frame_delay_channel #(
            .WIDTH         (WIDTH),
            .DEFAULT_DELAY (DEFAULT_DELAY),
            .TRIGGER       (TRIGGER_MASK[g])
        ) u_chan (
            .clk          (clk),
            .resetN       (resetN),
            .sof_i        (bus.startOfFrame),
            .in_i         (bus.input_signal[g]),
            .clear_i      (bus.clear[g]),
            .load_i       (bus.load[g]),
            .load_value_i (bus.load_value),
            .out_o        (out_vec[g]),
            .pulse_o      (pulse_vec[g]),
            .counting_c   (counting_c[g])
        );
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |counting_c;
        end
    end

    assign bus.output_signal = out_vec;
    assign bus.output_pulse  = pulse_vec;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_multi_frame_delay.sv
// Directed bench for multi_frame_delay: ch1 in trigger mode, others in hold mode, D defaults to 5.
module tb_multi_frame_delay;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 5;

    logic clk;
    logic resetN;
    int   n_tests;
    int   n_fail;

    multi_frame_delay_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    multi_frame_delay #(
        .CHANNELS      (CH),
        .WIDTH         (W),
        .DEFAULT_DELAY (5),
        .TRIGGER_MASK  (4'b0010)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: strobes applied on the falling edge, sampled 1ns after the rising edge.
    task automatic cyc(input logic sof, input logic [CH-1:0] clr, input logic [CH-1:0] ld,
                       input logic [W-1:0] lv);
        @(negedge clk);
        bus.startOfFrame = sof;
        bus.clear        = clr;
        bus.load         = ld;
        bus.load_value   = lv;
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
        bus.clear        = '0;
        bus.load         = '0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, '0, '0, '0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetN  = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.input_signal = '0;
        bus.clear        = '0;
        bus.load         = '0;
        bus.load_value   = '0;

        #23;
        check_eq("rst_sig",   32'(bus.output_signal), 32'h0);
        check_eq("rst_pulse", 32'(bus.output_pulse),  32'h0);
        check_eq("rst_busy",  32'(bus.busy),          32'h0);
        @(negedge clk);
        resetN = 1'b1;
        cyc(1'b0, '0, '0, '0);
        check_eq("busy_after_rst", 32'(bus.busy), 32'h1);

        // Hold mode ch0, D=5: done one clock after the 6th enabled frame
        bus.input_signal = 4'b0001;
        frames(5);
        check_eq("hold_5_frames", 32'(bus.output_signal), 32'h0);
        frames(1);
        check_eq("hold_6th_sig",   32'(bus.output_signal), 32'h1);
        check_eq("hold_6th_pulse", 32'(bus.output_pulse),  32'h1);
        cyc(1'b0, '0, '0, '0);
        check_eq("hold_pulse_1clk", 32'(bus.output_pulse),  32'h0);
        check_eq("hold_sticky",     32'(bus.output_signal), 32'h1);

        // Hold-mode pause: 3 high, 4 low, then 3 more high frames
        cyc(1'b0, 4'b0001, '0, '0);
        check_eq("clear_ch0", 32'(bus.output_signal), 32'h0);
        frames(3);
        bus.input_signal = 4'b0000;
        frames(4);
        check_eq("pause_low", 32'(bus.output_signal), 32'h0);
        bus.input_signal = 4'b0001;
        frames(2);
        check_eq("pause_2_more", 32'(bus.output_signal), 32'h0);
        frames(1);
        check_eq("pause_3_more", 32'(bus.output_signal), 32'h1);

        // Trigger mode ch1: frames ignored until a rising edge
        bus.input_signal = 4'b0000;
        frames(3);
        check_eq("trig_idle", 32'(bus.output_signal), 32'h1);
        bus.input_signal = 4'b0010;
        cyc(1'b0, '0, '0, '0);
        bus.input_signal = 4'b0000;
        frames(5);
        check_eq("trig_5_frames", 32'(bus.output_signal), 32'h1);
        frames(1);
        check_eq("trig_6th_sig",   32'(bus.output_signal),   32'h3);
        check_eq("trig_6th_pulse", 32'(bus.output_pulse[1]), 32'h1);

        // Edge coincident with startOfFrame: that frame is not counted
        cyc(1'b0, 4'b0010, '0, '0);
        check_eq("trig_clear", 32'(bus.output_signal), 32'h1);
        bus.input_signal = 4'b0010;
        frames(1);
        bus.input_signal = 4'b0000;
        frames(5);
        check_eq("trig_edge_sof_5", 32'(bus.output_signal), 32'h1);
        frames(1);
        check_eq("trig_edge_sof_6", 32'(bus.output_signal), 32'h3);

        // ch2: load 0 then clear -> first qualifying frame completes
        cyc(1'b0, '0, 4'b0100, 5'd0);
        cyc(1'b0, 4'b0100, '0, '0);
        check_eq("d0_before", 32'(bus.output_signal), 32'h3);
        bus.input_signal = 4'b0100;
        frames(1);
        check_eq("d0_sig",   32'(bus.output_signal),   32'h7);
        check_eq("d0_pulse", 32'(bus.output_pulse[2]), 32'h1);

        // ch3: clear+load+frame at counter 0 restarts with old delay, no pulse
        bus.input_signal = 4'b1000;
        frames(5);
        check_eq("cl_at_zero", 32'(bus.output_signal), 32'h7);
        cyc(1'b1, 4'b1000, 4'b1000, 5'd9);
        check_eq("cl_no_pulse", 32'(bus.output_pulse[3]), 32'h0);
        check_eq("cl_no_sig",   32'(bus.output_signal),    32'h7);
        frames(5);
        check_eq("cl_old_d_5", 32'(bus.output_signal), 32'h7);
        frames(1);
        check_eq("cl_old_d_6", 32'(bus.output_signal), 32'hf);
        cyc(1'b0, 4'b1000, '0, '0);
        frames(9);
        check_eq("new_d_9", 32'(bus.output_signal), 32'h7);
        frames(1);
        check_eq("new_d_10", 32'(bus.output_signal), 32'hf);

`ifdef MULTI_FRAME_DELAY_AUTO_RESTART_EN
        // Auto-restart on ch0 with D=2: pulse every 3 frames, level stays high
        bus.input_signal = 4'b0001;
        cyc(1'b0, '0, 4'b0001, 5'd2);
        cyc(1'b0, 4'b0001, '0, '0);
        frames(2);
        check_eq("ar_no_pulse_a", 32'(bus.output_pulse[0]), 32'h0);
        frames(1);
        check_eq("ar_pulse_a", 32'(bus.output_pulse[0]), 32'h1);
        frames(2);
        check_eq("ar_no_pulse_b", 32'(bus.output_pulse[0]),  32'h0);
        check_eq("ar_level",      32'(bus.output_signal[0]), 32'h1);
        frames(1);
        check_eq("ar_pulse_b", 32'(bus.output_pulse[0]), 32'h1);
`endif

        // Reset mid-count clears outputs immediately
        bus.input_signal = 4'b0001;
        cyc(1'b0, 4'b0001, '0, '0);
        frames(2);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_eq("midrst_sig",   32'(bus.output_signal), 32'h0);
        check_eq("midrst_pulse", 32'(bus.output_pulse),  32'h0);
        check_eq("midrst_busy",  32'(bus.busy),          32'h0);
        #20;
        resetN = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
